// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared widths and FSM state encoding for mem_access_ctrl
package mem_pkg;

    localparam int ADDR_W_DEF = 5;
    localparam int DATA_W_DEF = 8;
    localparam int CNT_W      = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        RESP   = 2'd3
    } state_t;

endpackage

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - single-request data-memory access sequencer
module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int ADDR_W        = ADDR_W_DEF,
    parameter int DATA_W        = DATA_W_DEF,
    parameter int STROBE_CYCLES = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_write,
    input  logic [ADDR_W-1:0]        req_addr,
    input  logic signed [DATA_W-1:0] req_wdata,
    output logic                     rsp_valid,
    output logic signed [DATA_W-1:0] rsp_rdata,
    output logic                     busy,
    output logic [ADDR_W-1:0]        address,
    output logic signed [DATA_W-1:0] writeData,
    output logic                     memRead,
    output logic                     memWrite,
    input  logic signed [DATA_W-1:0] readData
);

    localparam int               STROBE_EFF = (STROBE_CYCLES < 1) ? 1 : STROBE_CYCLES;
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(STROBE_EFF - 1);

    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     write_q, write_d;
    logic [ADDR_W-1:0]        address_q, address_d;
    logic signed [DATA_W-1:0] wdata_q, wdata_d;
    logic signed [DATA_W-1:0] rdata_q, rdata_d;
    logic                     rd_q, rd_d;
    logic                     wr_q, wr_d;
    logic                     rsp_valid_q, rsp_valid_d;

    // Strobes and rsp_valid are computed for the state being entered so they
    // come straight out of flops aligned with that state.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        write_d     = write_q;
        address_d   = address_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        rd_d        = 1'b0;
        wr_d        = 1'b0;
        rsp_valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d   = SETUP;
                    write_d   = req_write;
                    address_d = req_addr;
                    wdata_d   = req_wdata;
                end
            end
            SETUP: begin
                state_d = STROBE;
                cnt_d   = CNT_LAST;
                rd_d    = ~write_q;
                wr_d    = write_q;
            end
            STROBE: begin
                if (cnt_q == '0) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    if (!write_q) begin
                        rdata_d = readData;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                    rd_d  = ~write_q;
                    wr_d  = write_q;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            write_q     <= 1'b0;
            address_q   <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            write_q     <= write_d;
            address_q   <= address_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rdata_q;
    assign address   = address_q;
    assign writeData = wdata_q;
    assign memRead   = rd_q;
    assign memWrite  = wr_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - randomized self-checking bench for mem_access_ctrl
module tb_mem_access_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sel = 1'b0;
    logic       preload = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_write = 1'b0;
    logic [4:0] req_addr = '0;
    logic [7:0] req_wdata = '0;

    logic       rv_1, ready_1, rsp_valid_1, busy_1, rd_1, wr_1;
    logic       rv_3, ready_3, rsp_valid_3, busy_3, rd_3, wr_3;
    logic [7:0] rdata_1, wdata_1, readdata_1, rdata_3, wdata_3, readdata_3;
    logic [4:0] addr_1, addr_3;
    logic [7:0] mem_1 [32];
    logic [7:0] mem_3 [32];

    logic       m_ready, m_rsp_valid, m_busy, m_rd, m_wr;
    logic [7:0] m_rdata, m_wdata;
    logic [4:0] m_addr;

    logic [7:0] ref_mem [2][32];
    logic [7:0] last_rd [2];
    int         scyc [2] = '{1, 3};
    int         cmp = 0;
    int         err = 0;

    always #5 clk = ~clk;

    assign rv_1 = req_valid & ~sel;
    assign rv_3 = req_valid & sel;

    mem_access_ctrl #(.ADDR_W(5), .DATA_W(8), .STROBE_CYCLES(1)) dut_1 (
        .clk(clk), .rst(rst), .req_valid(rv_1), .req_ready(ready_1),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid_1), .rsp_rdata(rdata_1), .busy(busy_1),
        .address(addr_1), .writeData(wdata_1), .memRead(rd_1), .memWrite(wr_1),
        .readData(readdata_1)
    );

    mem_access_ctrl #(.ADDR_W(5), .DATA_W(8), .STROBE_CYCLES(3)) dut_3 (
        .clk(clk), .rst(rst), .req_valid(rv_3), .req_ready(ready_3),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid_3), .rsp_rdata(rdata_3), .busy(busy_3),
        .address(addr_3), .writeData(wdata_3), .memRead(rd_3), .memWrite(wr_3),
        .readData(readdata_3)
    );

    always_ff @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 32; i++) begin
                mem_1[i] <= 8'h00;
                mem_3[i] <= 8'h00;
            end
            mem_1[0]  <= 8'h99; mem_3[0]  <= 8'h99;
            mem_1[25] <= 8'h01; mem_3[25] <= 8'h01;
            mem_1[29] <= 8'h05; mem_3[29] <= 8'h05;
        end else begin
            if (wr_1) mem_1[addr_1] <= wdata_1;
            if (wr_3) mem_3[addr_3] <= wdata_3;
        end
    end
    assign readdata_1 = rd_1 ? mem_1[addr_1] : 8'hxx;
    assign readdata_3 = rd_3 ? mem_3[addr_3] : 8'hxx;

    assign m_ready     = sel ? ready_3     : ready_1;
    assign m_rsp_valid = sel ? rsp_valid_3 : rsp_valid_1;
    assign m_busy      = sel ? busy_3      : busy_1;
    assign m_rd        = sel ? rd_3        : rd_1;
    assign m_wr        = sel ? wr_3        : wr_1;
    assign m_rdata     = sel ? rdata_3     : rdata_1;
    assign m_wdata     = sel ? wdata_3     : wdata_1;
    assign m_addr      = sel ? addr_3      : addr_1;

    task automatic access(input int s, input logic w, input logic [4:0] a, input logic [7:0] d);
        int         t, lat, nrd, nwr;
        logic [7:0] exp;
        @(negedge clk);
        sel = s[0]; req_write = w; req_addr = a; req_wdata = d; req_valid = 1'b1;
        t = 0;
        while (!m_ready && t < 50) begin @(negedge clk); t++; end
        cmp++;
        if (!m_ready) begin
            err++; $display("FAIL accept_timeout s=%0d ready=%b required 1", s, m_ready);
            req_valid = 1'b0;
            return;
        end
        @(negedge clk);
        req_valid = 1'b0;
        req_write = 1'($urandom); req_addr = 5'($urandom); req_wdata = 8'($urandom);
        exp = w ? last_rd[s] : ref_mem[s][a];
        if (w) ref_mem[s][a] = d; else last_rd[s] = exp;
        lat = 1; nrd = 0; nwr = 0;
        while (!m_rsp_valid && lat < 40) begin
            cmp++;
            if ((m_rd && m_wr) !== 1'b0) begin
                err++; $display("FAIL strobe_excl memRead=%b memWrite=%b required not both", m_rd, m_wr);
            end
            cmp++;
            if (m_addr !== a || m_wdata !== d) begin
                err++; $display("FAIL latch_stable address=%0d writeData=%h required %0d %h", m_addr, m_wdata, a, d);
            end
            nrd += int'(m_rd); nwr += int'(m_wr);
            @(negedge clk); lat++;
        end
        cmp++;
        if (lat != scyc[s] + 2) begin
            err++; $display("FAIL latency s=%0d got cycle %0d required %0d", s, lat, scyc[s] + 2);
        end
        cmp++;
        if (nrd != (w ? 0 : scyc[s]) || nwr != (w ? scyc[s] : 0)) begin
            err++; $display("FAIL strobe_count rd=%0d wr=%0d required %0d %0d", nrd, nwr,
                            w ? 0 : scyc[s], w ? scyc[s] : 0);
        end
        cmp++;
        if (m_rdata !== exp) begin
            err++; $display("FAIL rsp_rdata s=%0d w=%b addr=%0d got %h required %h", s, w, a, m_rdata, exp);
        end
        cmp++;
        if (m_rd !== 1'b0 || m_wr !== 1'b0 || m_addr !== a || m_busy !== 1'b1) begin
            err++; $display("FAIL resp_state rd=%b wr=%b addr=%0d busy=%b required 0 0 %0d 1", m_rd, m_wr, m_addr, m_busy, a);
        end
        @(negedge clk);
        cmp++;
        if (m_rsp_valid !== 1'b0 || m_busy !== 1'b0 || m_ready !== 1'b1) begin
            err++; $display("FAIL back_to_idle rsp_valid=%b busy=%b ready=%b required 0 0 1", m_rsp_valid, m_busy, m_ready);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        preload = 1'b0;
        cmp++;
        if ({rsp_valid_1, busy_1, rd_1, wr_1, rdata_1, addr_1, wdata_1} !== '0) begin
            err++; $display("FAIL reset_values_1 got %b required all zero", {rsp_valid_1, busy_1, rd_1, wr_1, rdata_1, addr_1, wdata_1});
        end
        cmp++;
        if ({rsp_valid_3, busy_3, rd_3, wr_3, rdata_3, addr_3, wdata_3} !== '0) begin
            err++; $display("FAIL reset_values_3 got %b required all zero", {rsp_valid_3, busy_3, rd_3, wr_3, rdata_3, addr_3, wdata_3});
        end
        rst = 1'b0;
        @(negedge clk);
        cmp++;
        if (ready_1 !== 1'b1 || ready_3 !== 1'b1) begin
            err++; $display("FAIL reset_ready got %b%b required 11", ready_1, ready_3);
        end
    endtask

    task automatic test_back_to_back();
        int t, low, got;
        @(negedge clk);
        sel = 1'b0; req_write = 1'b0; req_addr = 5'd25; req_valid = 1'b1;
        t = 0;
        while (!ready_1 && t < 50) begin @(negedge clk); t++; end
        @(negedge clk);
        req_addr = 5'd29;
        low = 0; got = 0;
        while (!ready_1 && low < 20) begin
            cmp++;
            if (addr_1 !== 5'd25) begin
                err++; $display("FAIL b2b_addr_hold got %0d required 25", addr_1);
            end
            if (rsp_valid_1) begin
                got++;
                cmp++;
                if (rdata_1 !== ref_mem[0][25]) begin
                    err++; $display("FAIL b2b_first_rdata got %h required %h", rdata_1, ref_mem[0][25]);
                end
            end
            low++;
            @(negedge clk);
        end
        cmp++;
        if (low != 3 || got != 1) begin
            err++; $display("FAIL b2b_ready_gap low=%0d responses=%0d required 3 1", low, got);
        end
        @(negedge clk);
        req_valid = 1'b0;
        t = 0;
        while (!rsp_valid_1 && t < 20) begin @(negedge clk); t++; end
        cmp++;
        if (rsp_valid_1 !== 1'b1 || rdata_1 !== ref_mem[0][29] || addr_1 !== 5'd29) begin
            err++; $display("FAIL b2b_second rsp_valid=%b rdata=%h addr=%0d required 1 %h 29", rsp_valid_1, rdata_1, addr_1, ref_mem[0][29]);
        end
        last_rd[0] = ref_mem[0][29];
        @(negedge clk);
    endtask

    task automatic test_reset_in_strobe();
        int t;
        @(negedge clk);
        sel = 1'b1; req_write = 1'b0; req_addr = 5'd0; req_valid = 1'b1;
        t = 0;
        while (!ready_3 && t < 50) begin @(negedge clk); t++; end
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        cmp++;
        if (rd_3 !== 1'b1) begin
            err++; $display("FAIL mid_strobe_rd got %b required 1", rd_3);
        end
        rst = 1'b1;
        @(negedge clk);
        cmp++;
        if (rd_3 !== 1'b0 || rsp_valid_3 !== 1'b0 || rdata_3 !== 8'h00 || busy_3 !== 1'b0) begin
            err++; $display("FAIL reset_abort rd=%b rsp_valid=%b rdata=%h busy=%b required 0 0 00 0", rd_3, rsp_valid_3, rdata_3, busy_3);
        end
        rst = 1'b0;
        last_rd[0] = 8'h00; last_rd[1] = 8'h00;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            cmp++;
            if (rsp_valid_3 !== 1'b0 || ready_3 !== 1'b1) begin
                err++; $display("FAIL post_reset_idle rsp_valid=%b ready=%b required 0 1", rsp_valid_3, ready_3);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 30; i++) begin
            access(int'($urandom_range(0, 1)), 1'($urandom), 5'($urandom), 8'($urandom));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            ref_mem[0][i] = 8'h00; ref_mem[1][i] = 8'h00;
        end
        ref_mem[0][0] = 8'h99;  ref_mem[1][0] = 8'h99;
        ref_mem[0][25] = 8'h01; ref_mem[1][25] = 8'h01;
        ref_mem[0][29] = 8'h05; ref_mem[1][29] = 8'h05;
        last_rd[0] = 8'h00; last_rd[1] = 8'h00;

        test_reset();
        access(0, 1'b0, 5'd0, 8'h00);
        access(0, 1'b1, 5'd5, 8'h7F);
        access(0, 1'b0, 5'd5, 8'h00);
        test_back_to_back();
        access(1, 1'b0, 5'd0, 8'h00);
        access(1, 1'b1, 5'd31, 8'h80);
        access(1, 1'b0, 5'd31, 8'h00);
        test_reset_in_strobe();
        test_random();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish, required completion");
        $fatal(1);
    end

endmodule
